elink_trig_vote_monitor: RTL

Sits directly downstream of the e-link trigger voter. It consumes the 14-bit voted word: bits [13:12] are the confidence (2 = unanimous, 1 = majority, 0 = no majority) and bits [11:0] are the trigger data. It forwards clean trigger data and substitutes the last good word when there is no majority. It keeps saturating per-confidence statistics and runs a link-health state machine that raises a fault interrupt on persistent disagreement.

---
 rtl/elink_trig_vote_monitor.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/elink_trig_vote_monitor.sv
`default_nettype none
// ============================================================================
// elink_trig_vote_monitor: forwards voted e-link trigger data, substitutes the
// last good word on no-majority, keeps statistics and tracks link health.
// Revision: 1.0
// ============================================================================
module elink_trig_vote_monitor #(
    parameter int CNT_WIDTH      = 16,
    parameter int DEGRADE_THRESH = 4,
    parameter int FAULT_THRESH   = 16,
    parameter int RECOVER_COUNT  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [13:0]          voted_in,
    input  logic                 voted_valid,
    input  logic                 cnt_clear,
    output logic [11:0]          trig_out,
    output logic                 trig_valid,
    output logic                 trig_substituted,
    output logic [1:0]           link_state,
    output logic                 fault_irq,
    output logic [CNT_WIDTH-1:0] cnt_unanimous,
    output logic [CNT_WIDTH-1:0] cnt_majority,
    output logic [CNT_WIDTH-1:0] cnt_nomajority
);

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_DEGRADED = 2'd1,
        ST_FAULT    = 2'd2
    } state_t;

    localparam logic [7:0]           C_DEGRADE = 8'(DEGRADE_THRESH);
    localparam logic [7:0]           C_FAULT   = 8'(FAULT_THRESH);
    localparam logic [7:0]           C_RECOVER = 8'(RECOVER_COUNT);
    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = CNT_WIDTH'(1);

    state_t                state_q, state_d;
    logic [11:0]           trig_out_q, trig_out_d;
    logic                  trig_valid_q, trig_valid_d;
    logic                  subst_q, subst_d;
    logic                  fault_irq_q, fault_irq_d;
    logic [11:0]           last_good_q, last_good_d;
    logic [7:0]            bad_run_q, bad_run_d;
    logic [7:0]            good_run_q, good_run_d;
    logic [CNT_WIDTH-1:0]  cnt_unan_q, cnt_unan_d;
    logic [CNT_WIDTH-1:0]  cnt_maj_q, cnt_maj_d;
    logic [CNT_WIDTH-1:0]  cnt_nomaj_q, cnt_nomaj_d;

    logic [1:0]  w_conf;
    logic        w_good;
    logic        w_unan;
    logic [7:0]  w_bad_inc;
    logic [7:0]  w_good_inc;

    always_comb begin
        w_conf     = voted_in[13:12];
        w_unan     = (w_conf == 2'd2);
        w_good     = (w_conf == 2'd1) || w_unan;
        w_bad_inc  = (bad_run_q  == 8'hFF) ? 8'hFF : bad_run_q  + 8'd1;
        w_good_inc = (good_run_q == 8'hFF) ? 8'hFF : good_run_q + 8'd1;

        state_d      = state_q;
        trig_out_d   = trig_out_q;
        subst_d      = subst_q;
        last_good_d  = last_good_q;
        bad_run_d    = bad_run_q;
        good_run_d   = good_run_q;
        trig_valid_d = voted_valid;
        fault_irq_d  = 1'b0;
        cnt_unan_d   = cnt_unan_q;
        cnt_maj_d    = cnt_maj_q;
        cnt_nomaj_d  = cnt_nomaj_q;

        if (voted_valid) begin
            bad_run_d  = w_good ? 8'd0 : w_bad_inc;
            good_run_d = w_unan ? w_good_inc : 8'd0;

            // Thresholds compare against the post-increment run length.
            case (state_q)
                ST_OK: begin
                    if (!w_good && (w_bad_inc >= C_DEGRADE))
                        state_d = ST_DEGRADED;
                end
                ST_DEGRADED: begin
                    if (!w_good && (w_bad_inc >= C_FAULT))
                        state_d = ST_FAULT;
                    else if (w_unan && (w_good_inc >= C_RECOVER))
                        state_d = ST_OK;
                end
                ST_FAULT: begin
                    if (w_unan && (w_good_inc >= C_RECOVER))
                        state_d = ST_DEGRADED;
                end
                default: state_d = ST_OK;
            endcase

            if (state_d != state_q)
                good_run_d = 8'd0;
            fault_irq_d = (state_d == ST_FAULT) && (state_q != ST_FAULT);

            if (w_good)
                last_good_d = voted_in[11:0];
            if (state_q == ST_FAULT) begin
                trig_out_d = 12'd0;
                subst_d    = 1'b1;
            end else if (w_good) begin
                trig_out_d = voted_in[11:0];
                subst_d    = 1'b0;
            end else begin
                trig_out_d = last_good_q;
                subst_d    = 1'b1;
            end
        end

        if (cnt_clear) begin
            cnt_unan_d  = '0;
            cnt_maj_d   = '0;
            cnt_nomaj_d = '0;
        end else if (voted_valid) begin
            if (w_unan) begin
                if (cnt_unan_q != C_CNT_MAX) cnt_unan_d = cnt_unan_q + C_CNT_ONE;
            end else if (w_good) begin
                if (cnt_maj_q != C_CNT_MAX) cnt_maj_d = cnt_maj_q + C_CNT_ONE;
            end else begin
                if (cnt_nomaj_q != C_CNT_MAX) cnt_nomaj_d = cnt_nomaj_q + C_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_OK;
            trig_out_q   <= 12'd0;
            trig_valid_q <= 1'b0;
            subst_q      <= 1'b0;
            fault_irq_q  <= 1'b0;
            last_good_q  <= 12'd0;
            bad_run_q    <= 8'd0;
            good_run_q   <= 8'd0;
            cnt_unan_q   <= '0;
            cnt_maj_q    <= '0;
            cnt_nomaj_q  <= '0;
        end else begin
            state_q      <= state_d;
            trig_out_q   <= trig_out_d;
            trig_valid_q <= trig_valid_d;
            subst_q      <= subst_d;
            fault_irq_q  <= fault_irq_d;
            last_good_q  <= last_good_d;
            bad_run_q    <= bad_run_d;
            good_run_q   <= good_run_d;
            cnt_unan_q   <= cnt_unan_d;
            cnt_maj_q    <= cnt_maj_d;
            cnt_nomaj_q  <= cnt_nomaj_d;
        end
    end

    assign trig_out         = trig_out_q;
    assign trig_valid       = trig_valid_q;
    assign trig_substituted = subst_q;
    assign link_state       = state_q;
    assign fault_irq        = fault_irq_q;
    assign cnt_unanimous    = cnt_unan_q;
    assign cnt_majority     = cnt_maj_q;
    assign cnt_nomajority   = cnt_nomaj_q;

endmodule
`default_nettype wire
